// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU and load result channels in, register-array write port and pending mask out.
// The arbiter takes the slave view; the producer and register-array side take the master view.
interface writeback_arbiter_if #(
    parameter int register_num        = 32,
    parameter int register_width      = 32,
    parameter int register_num_length = $clog2(register_num)
);
    logic                           alu_valid;
    logic                           alu_ready;
    logic [register_num_length-1:0] alu_reg_address;
    logic [register_width-1:0]      alu_data;
    logic                           alu_byte;

    logic                           mem_valid;
    logic                           mem_ready;
    logic [register_num_length-1:0] mem_reg_address;
    logic [register_width-1:0]      mem_data;
    logic                           mem_byte;

    logic                           write_word_enable;
    logic                           write_byte_enable;
    logic [register_num_length-1:0] write_reg_address;
    logic [register_width-1:0]      write_data;
    logic [register_num-1:0]        pending_mask;

    modport slave (
        input  alu_valid, alu_reg_address, alu_data, alu_byte,
        input  mem_valid, mem_reg_address, mem_data, mem_byte,
        output alu_ready, mem_ready,
        output write_word_enable, write_byte_enable, write_reg_address, write_data,
        output pending_mask
    );

    modport master (
        output alu_valid, alu_reg_address, alu_data, alu_byte,
        output mem_valid, mem_reg_address, mem_data, mem_byte,
        input  alu_ready, mem_ready,
        input  write_word_enable, write_byte_enable, write_reg_address, write_data,
        input  pending_mask
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU (priority) and buffered load results onto one register-array write port; 1-cycle registered latency.
// Loads back-pressure when the FIFO is full; the ALU is stalled one cycle once the FIFO head has lost starve_limit times.
module writeback_arbiter #(
    parameter int register_num        = 32,
    parameter int register_width      = 32,
    parameter int register_num_length = $clog2(register_num),
    parameter int buf_depth           = 2,
    parameter int starve_limit        = 4
) (
    input  logic                clk,
    input  logic                rst,
    writeback_arbiter_if.slave  wb
);
    localparam int PW = $clog2(buf_depth);
    localparam int CW = $clog2(buf_depth + 1);
    localparam int SW = $clog2(starve_limit + 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SW-1:0] starve_q, starve_d;

    logic [register_num_length-1:0] buf_addr_q [buf_depth];
    logic [register_width-1:0]      buf_data_q [buf_depth];
    logic                           buf_byte_q [buf_depth];

    logic                           wen_q, wen_d;
    logic                           ben_q, ben_d;
    logic [register_num_length-1:0] waddr_q, waddr_d;
    logic [register_width-1:0]      wdata_q, wdata_d;

    logic                    alu_ready;
    logic                    mem_ready;
    logic                    fifo_ne;
    logic                    alu_win;
    logic                    pop;
    logic                    bypass;
    logic                    push;
    logic [register_num-1:0] mask;
    logic [PW-1:0]           off;

    always_comb begin
        alu_ready = (starve_q != SW'(starve_limit));
        mem_ready = (count_q < CW'(buf_depth));
        fifo_ne   = (count_q != '0);
        alu_win   = wb.alu_valid && alu_ready;
        pop       = !alu_win && fifo_ne;
        bypass    = !alu_win && !fifo_ne && wb.mem_valid;
        // A losing load is still buffered, even into an empty FIFO.
        push      = wb.mem_valid && mem_ready && !bypass;

        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        wen_d   = 1'b0;
        ben_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_win) begin
            wen_d   = !wb.alu_byte;
            ben_d   = wb.alu_byte;
            waddr_d = wb.alu_reg_address;
            wdata_d = wb.alu_data;
        end else if (pop) begin
            wen_d   = !buf_byte_q[rd_ptr_q];
            ben_d   = buf_byte_q[rd_ptr_q];
            waddr_d = buf_addr_q[rd_ptr_q];
            wdata_d = buf_data_q[rd_ptr_q];
        end else if (bypass) begin
            wen_d   = !wb.mem_byte;
            ben_d   = wb.mem_byte;
            waddr_d = wb.mem_reg_address;
            wdata_d = wb.mem_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        mask = '0;
        off  = '0;
        for (int i = 0; i < buf_depth; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) begin
                mask[buf_addr_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            ben_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            ben_q    <= ben_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= wb.mem_reg_address;
            buf_data_q[wr_ptr_q] <= wb.mem_data;
            buf_byte_q[wr_ptr_q] <= wb.mem_byte;
        end
    end

    assign wb.alu_ready         = alu_ready;
    assign wb.mem_ready         = mem_ready;
    assign wb.write_word_enable = wen_q;
    assign wb.write_byte_enable = ben_q;
    assign wb.write_reg_address = waddr_q;
    assign wb.write_data        = wdata_q;
    assign wb.pending_mask      = mask;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter, scored against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int NREG  = 32;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          b;
    } wr_t;

    typedef struct packed {
        int  cyc;
        wr_t w;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    wr_t  mq[$];
    exp_t eq[$];
    int   starve = 0;

    writeback_arbiter_if #(.register_num(NREG), .register_width(W)) bus ();

    writeback_arbiter #(
        .register_num (NREG),
        .register_width(W),
        .buf_depth    (DEPTH),
        .starve_limit (LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m = '0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        return m;
    endfunction

    // Drive one cycle of inputs, check handshake/mask, and advance the reference model.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [W-1:0] ad, input logic ab,
                        input logic mv, input logic [AW-1:0] ma, input logic [W-1:0] md, input logic mb,
                        output bit a_acc, output bit m_acc);
        bit  a_rdy, m_rdy, nonempty, popped, bypass, gv;
        wr_t w;
        @(negedge clk);
        bus.alu_valid = av; bus.alu_reg_address = aa; bus.alu_data = ad; bus.alu_byte = ab;
        bus.mem_valid = mv; bus.mem_reg_address = ma; bus.mem_data = md; bus.mem_byte = mb;
        #1;
        a_rdy = (starve != LIMIT);
        m_rdy = (mq.size() < DEPTH);
        chk("alu_ready", bus.alu_ready, a_rdy);
        chk("mem_ready", bus.mem_ready, m_rdy);
        chk("pending_mask", bus.pending_mask, model_mask());
        nonempty = (mq.size() > 0);
        popped = 0; bypass = 0; gv = 0; w = '0;
        a_acc = av && a_rdy;
        m_acc = mv && m_rdy;
        if (a_acc) begin
            w = '{aa, ad, ab}; gv = 1;
        end else if (nonempty) begin
            w = mq.pop_front(); gv = 1; popped = 1;
        end else if (mv) begin
            w = '{ma, md, mb}; gv = 1; bypass = 1;
        end
        if (m_acc && !bypass) mq.push_back('{ma, md, mb});
        if (gv) eq.push_back('{cyc + 1, w});
        if (!nonempty || popped) starve = 0;
        else if (a_acc) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    endtask

    task automatic idle(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0, x, y);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write, on the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.write_word_enable || bus.write_byte_enable) begin
                chk("wr_both_en", {1'b0, bus.write_word_enable & bus.write_byte_enable}, 0);
                if (eq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got write r%0d data 0x%0h, expected none (cycle %0d)",
                             bus.write_reg_address, bus.write_data, cyc);
                end else begin
                    e = eq.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", bus.write_reg_address, e.w.a);
                    chk("wr_data", bus.write_data, e.w.d);
                    chk("wr_byte_en", bus.write_byte_enable, e.w.b);
                end
            end
        end
    end

    initial begin
        bit a_acc, m_acc;
        logic av, ab, mv, mb;
        logic [AW-1:0] aa, ma;
        logic [W-1:0] ad, md;

        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_reg_address = '0; bus.alu_data = '0; bus.alu_byte = 0;
        bus.mem_valid = 0; bus.mem_reg_address = '0; bus.mem_data = '0; bus.mem_byte = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_mem_ready", bus.mem_ready, 1);
        chk("rst_word_en", bus.write_word_enable, 0);
        chk("rst_byte_en", bus.write_byte_enable, 0);
        chk("rst_mask", bus.pending_mask, 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU only
        step(1, 5, 32'hDEADBEEF, 0, 0, '0, '0, 0, a_acc, m_acc);
        @(posedge clk); #2;
        chk("alu_word_en", bus.write_word_enable, 1);
        chk("alu_byte_en", bus.write_byte_enable, 0);
        chk("alu_addr", bus.write_reg_address, 5);
        chk("alu_data", bus.write_data, 32'hDEADBEEF);
        chk("alu_mask", bus.pending_mask, 0);

        // Load bypass
        step(0, '0, '0, 0, 1, 3, 32'h000000A5, 1, a_acc, m_acc);
        @(posedge clk); #2;
        chk("byp_byte_en", bus.write_byte_enable, 1);
        chk("byp_word_en", bus.write_word_enable, 0);
        chk("byp_addr", bus.write_reg_address, 3);
        chk("byp_mask", bus.pending_mask, 0);

        // Contention, fill and starvation
        step(1, 1, 32'h11, 0, 1, 7, 32'h70, 0, a_acc, m_acc);
        step(1, 2, 32'h22, 0, 1, 9, 32'h90, 1, a_acc, m_acc);
        @(posedge clk); #2;
        chk("fill_mask", bus.pending_mask, 32'h280);
        chk("fill_mem_ready", bus.mem_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, AW'(10 + i), W'(i), 0, 1, 11, 32'hB0, 0, a_acc, m_acc);
            chk("starve_alu_ready", bus.alu_ready, (i == 3) ? 0 : 1);
            chk("held_load", m_acc, 0);
        end
        @(posedge clk); #2;
        chk("starve_pop_addr", bus.write_reg_address, 7);
        chk("starve_pop_en", bus.write_word_enable, 1);
        step(1, 14, 32'h44, 0, 1, 11, 32'hB0, 0, a_acc, m_acc);
        chk("post_mask", bus.pending_mask, 32'h200);
        chk("post_mem_ready", bus.mem_ready, 1);
        chk("post_alu_ready", bus.alu_ready, 1);
        idle(DEPTH + 1);

        // Simultaneous pop and push at count 1
        step(1, 15, 32'h55, 0, 1, 20, 32'h2000, 0, a_acc, m_acc);
        for (int k = 0; k < 5; k++) begin
            step(0, '0, '0, 0, 1, AW'(21 + k), W'(32'h2100 + k), 1'(k), a_acc, m_acc);
            chk("pp_mask", bus.pending_mask, 32'h1 << (20 + k));
            chk("pp_mem_ready", bus.mem_ready, 1);
        end
        idle(DEPTH + 1);

        // Randomized traffic honouring the hold-until-accepted rule
        av = 0; mv = 0; aa = '0; ma = '0; ad = '0; md = '0; ab = 0; mb = 0;
        a_acc = 1; m_acc = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!av || a_acc) begin
                av = ($urandom_range(0, 9) < 6);
                aa = AW'($urandom_range(0, NREG - 1));
                ad = $urandom;
                ab = 1'($urandom_range(0, 1));
            end
            if (!mv || m_acc) begin
                mv = ($urandom_range(0, 9) < 5);
                ma = AW'($urandom_range(0, NREG - 1));
                md = $urandom;
                mb = 1'($urandom_range(0, 1));
            end
            step(av, aa, ad, ab, mv, ma, md, mb, a_acc, m_acc);
        end
        idle(DEPTH + 1);

        // Async reset with a full FIFO and a write in flight
        step(1, 1, 32'hA1, 0, 1, 12, 32'hC0, 0, a_acc, m_acc);
        step(1, 2, 32'hA2, 0, 1, 13, 32'hD0, 0, a_acc, m_acc);
        step(1, 3, 32'hA3, 0, 0, '0, '0, 0, a_acc, m_acc);
        @(posedge clk); #2;
        chk("inflight_en", bus.write_word_enable, 1);
        rst = 1'b1;
        bus.alu_valid = 0;
        bus.mem_valid = 0;
        #1;
        chk("arst_word_en", bus.write_word_enable, 0);
        chk("arst_byte_en", bus.write_byte_enable, 0);
        chk("arst_mask", bus.pending_mask, 0);
        chk("arst_mem_ready", bus.mem_ready, 1);
        chk("arst_alu_ready", bus.alu_ready, 1);
        mq.delete();
        eq.delete();
        starve = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);

        chk("exp_drained", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
